// File: rtl/tour_cmd_if.sv
// Bus between the tour replayer, the solver, the UART path and the command processor.
// master = tour_cmd, slave = the surrounding logic.
interface tour_cmd_if;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, cmd, cmd_rdy, resp
    );
    modport slave (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as two-leg movement commands (vertical then horizontal),
// otherwise passes UART commands straight through to the command processor.
module tour_cmd (
    input  logic        clk,
    input  logic        rst,
    tour_cmd_if.master  bus
);
    typedef enum logic [2:0] {IDLE, VERT, HOLDV, HORZ, HOLDH} state_t;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;
    localparam logic [4:0] LAST_MV = 5'd23;

    state_t      r_state, w_next;
    logic [4:0]  r_mv_indx, w_mv_nxt;
    logic [1:0]  w_dx_mag, w_dy_mag;
    logic        w_dx_neg, w_dy_neg, w_zero;
    logic [15:0] w_vcmd, w_hcmd;
    logic [7:0]  w_vhead, w_hhead;

    // Lowest set bit wins so a glitchy multi-hot move still decodes to a legal jump.
    always_comb begin
        w_dx_mag = 2'd0;
        w_dy_mag = 2'd0;
        w_dx_neg = 1'b0;
        w_dy_neg = 1'b0;
        w_zero   = 1'b0;
        casez (bus.move)
            8'b???????1: begin w_dx_mag = 2'd1;                  w_dy_mag = 2'd2;                  end
            8'b??????10: begin w_dx_mag = 2'd1; w_dx_neg = 1'b1; w_dy_mag = 2'd2;                  end
            8'b?????100: begin w_dx_mag = 2'd2; w_dx_neg = 1'b1; w_dy_mag = 2'd1;                  end
            8'b????1000: begin w_dx_mag = 2'd2; w_dx_neg = 1'b1; w_dy_mag = 2'd1; w_dy_neg = 1'b1; end
            8'b???10000: begin w_dx_mag = 2'd1; w_dx_neg = 1'b1; w_dy_mag = 2'd2; w_dy_neg = 1'b1; end
            8'b??100000: begin w_dx_mag = 2'd1;                  w_dy_mag = 2'd2; w_dy_neg = 1'b1; end
            8'b?1000000: begin w_dx_mag = 2'd2;                  w_dy_mag = 2'd1; w_dy_neg = 1'b1; end
            8'b10000000: begin w_dx_mag = 2'd2;                  w_dy_mag = 2'd1;                  end
            default:     w_zero = 1'b1;
        endcase
    end

    assign w_vhead = w_dy_neg ? HEAD_S : HEAD_N;
    assign w_hhead = w_zero ? HEAD_N : (w_dx_neg ? HEAD_W : HEAD_E);
    assign w_vcmd  = {4'h2, w_vhead, 2'b00, w_dy_mag};
    assign w_hcmd  = {4'h3, w_hhead, 2'b00, w_dx_mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mv_indx <= 5'd0;
        end else begin
            r_state   <= w_next;
            r_mv_indx <= w_mv_nxt;
        end
    end

    // Handshake: clr_cmd_rdy only matters while offering, send_resp only while holding.
    always_comb begin
        w_next       = r_state;
        w_mv_nxt     = r_mv_indx;
        bus.cmd      = bus.cmd_UART;
        bus.cmd_rdy  = 1'b0;
        bus.resp     = 8'h5A;
        case (r_state)
            IDLE: begin
                bus.cmd_rdy = bus.cmd_rdy_UART;
                bus.resp    = 8'hA5;
                if (bus.start_tour) begin
                    w_next   = VERT;
                    w_mv_nxt = 5'd0;
                end
            end
            VERT: begin
                bus.cmd     = w_vcmd;
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) w_next = HOLDV;
            end
            HOLDV: begin
                bus.cmd = w_vcmd;
                if (bus.send_resp) w_next = HORZ;
            end
            HORZ: begin
                bus.cmd     = w_hcmd;
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) w_next = HOLDH;
            end
            HOLDH: begin
                bus.cmd = w_hcmd;
                if (r_mv_indx == LAST_MV) bus.resp = 8'hA5;
                if (bus.send_resp) begin
                    if (r_mv_indx == LAST_MV) begin
                        w_next = IDLE;
                    end else begin
                        w_next   = VERT;
                        w_mv_nxt = r_mv_indx + 5'd1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.mv_indx = r_mv_indx;
endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have one clock, `clk`, input, 1 bit; all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have `start_tour`, input, 1 bit: solver finished, begin replaying the tour.
REQ-004 SHALL have `move`, input, 8 bits: one-hot knight move from the solver at index `mv_indx`.
REQ-005 SHALL have `mv_indx`, output, 5 bits: index of the move currently being replayed.
REQ-006 SHALL have `cmd_UART`, input, 16 bits: command from the UART path.
REQ-007 SHALL have `cmd_rdy_UART`, input, 1 bit: UART command valid.
REQ-008 SHALL have `cmd`, output, 16 bits: command to the command processor.
REQ-009 SHALL have `cmd_rdy`, output, 1 bit: `cmd` valid.
REQ-010 SHALL have `clr_cmd_rdy`, input, 1 bit: command processor has taken `cmd`.
REQ-011 SHALL have `send_resp`, input, 1 bit: command processor has completed the command.
REQ-012 SHALL have `resp`, output, 8 bits: response byte to the UART.

Function
REQ-013 Command format SHALL be: [15:12] opcode, [11:4] heading, [3:0] squares.
- Opcode 4'h2: move.
- Opcode 4'h3: move with fanfare.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
REQ-014 Move decode (dx,dy) SHALL be:
- bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
- bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
REQ-015 Non-one-hot `move` SHALL decode by its lowest set bit; `move`==0 SHALL decode as (0,0) with heading N for both legs.
REQ-016 Each move SHALL issue two legs:
- Vertical leg: opcode 2, heading N if dy>0 else S, squares |dy|.
- Horizontal leg: opcode 3, heading E if dx>0 else W, squares |dx|.
REQ-017 The state machine SHALL have states IDLE, VERT, HOLDV, HORZ, HOLDH.
REQ-018 In IDLE:
- `cmd`=`cmd_UART` and `cmd_rdy`=`cmd_rdy_UART`, combinationally.
- `start_tour`=1 SHALL clear `mv_indx` to 0 and go to VERT next cycle.
REQ-019 In VERT:
- `cmd` = vertical leg of `move`; `cmd_rdy`=1.
- `clr_cmd_rdy`=1 -> HOLDV.
REQ-020 In HOLDV:
- `cmd` held; `cmd_rdy`=0.
- `send_resp`=1 -> HORZ.
REQ-021 In HORZ:
- `cmd` = horizontal leg; `cmd_rdy`=1.
- `clr_cmd_rdy`=1 -> HOLDH.
REQ-022 In HOLDH:
- `cmd_rdy`=0.
- `send_resp`=1 with `mv_indx`<23: increment `mv_indx`, go to VERT.
- `send_resp`=1 with `mv_indx`==23: go to IDLE; `mv_indx` holds 23.
REQ-023 A tour SHALL be exactly 24 moves (indices 0..23), i.e. 48 commands.
REQ-024 `mv_indx` SHALL NOT wrap; it changes only as stated in REQ-018 and REQ-022.
REQ-025 `start_tour` outside IDLE SHALL be ignored; `cmd_rdy_UART` outside IDLE SHALL be ignored (not muxed to `cmd`/`cmd_rdy`).
REQ-026 `clr_cmd_rdy` in HOLDV/HOLDH and `send_resp` in VERT/HORZ SHALL be ignored; if both are asserted in VERT/HORZ, only `clr_cmd_rdy` SHALL act.
REQ-027 `resp` SHALL be:
- 8'h5A while the state is not IDLE, except 8'hA5 in HOLDH when `mv_indx`==23.
- 8'hA5 in IDLE.
REQ-028 `move` SHALL be sampled combinationally from the current `mv_indx`; the solver output is stable during the tour.

Reset
REQ-029 `rst`=1 SHALL immediately force state IDLE and `mv_indx`=0.
- While reset, `cmd`/`cmd_rdy` mirror the UART inputs and `resp`=8'hA5.
REQ-030 Reset asserted mid-tour SHALL abort the tour; after release, no tour command is issued until the next `start_tour`.

Verification
REQ-031 Reset scenario: `rst` pulse, `cmd_UART`=16'h1234, `cmd_rdy_UART`=1 -> `cmd`=16'h1234, `cmd_rdy`=1, `mv_indx`=0, `resp`=8'hA5.
REQ-032 Single-move scenario: `start_tour`, `move`=8'h01 -> `cmd`=16'h2002 with `cmd_rdy`=1; after clr/resp, `cmd`=16'h3BF1.
REQ-033 Negative-move scenario: `move`=8'h08 -> 16'h27F1 then 16'h33F2; `move`=8'h40 -> 16'h27F1 then 16'h3BF2.
REQ-034 Full-tour scenario: drive 24 moves with a responder -> exactly 48 `cmd_rdy` rising edges, `mv_indx` 0..23, return to IDLE, `resp`=8'hA5 on the final leg.
REQ-035 Abort scenario: assert `rst` in HOLDV at `mv_indx`=5 -> IDLE, `mv_indx`=0; `start_tour` during the tour is ignored.
REQ-036 Handshake scenario: `cmd_rdy` stays high until `clr_cmd_rdy`; a simultaneous `send_resp` in VERT does not skip HOLDV.
